// File: rtl/sine_freq_estimator.sv
// sine_freq_estimator
//   Measures the frequency of a signed sample stream and reports it as an NCO
//   phase increment for a PB-bit accumulator: est = floor(2^(PB+NAVG) / D),
//   where D is the number of samples spanned by 2^NAVG rising crossings.
//
// Ports
//   clk              clock
//   rst              asynchronous, active-high reset
//   sample_clock_ce  sample strobe; sinewave is only looked at when high
//   sinewave         signed SB-bit samples
//   phase_inc_est    estimated phase increment, held between updates
//   est_valid        1-clk pulse when phase_inc_est updates
//   overrun          1-clk pulse when a window result is dropped (divider busy)
//   signal_lost      level; high from reset/timeout until the next est_valid
//
// Configuration
//   FREQ_EST_IIR_EN  when defined, each quotient is smoothed by a 1/4-gain IIR
//                    (first result after reset/timeout loads directly) and
//                    est_valid comes one clk later.

module sine_freq_estimator #(
   parameter int SB   = 12,
   parameter int PB   = 64,
   parameter int CW   = 24,
   parameter int NAVG = 4,
   parameter int HYST = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_clock_ce,
   input  logic [SB-1:0] sinewave,
   output logic [PB-1:0] phase_inc_est,
   output logic          est_valid,
   output logic          overrun,
   output logic          signal_lost
);
   localparam int DW = CW + 1;             // D can reach 2^CW
   localparam int IW = $clog2(PB + 1);
   localparam logic [NAVG:0]          XN       = (NAVG+1)'(1 << NAVG);
   localparam logic [CW-1:0]          CNT_MAX  = '1;
   localparam logic signed [SB-1:0]   NEG_HYST = SB'(-HYST);

   typedef enum logic {S_IDLE, S_MEASURE} state_t;

   // ---------------- crossing detector + window FSM ----------------
   state_t        state_q, state_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NAVG:0] xcnt_q, xcnt_d;
   logic          win_close, timeout, crossing;
   logic signed [SB-1:0] s;

   assign s        = $signed(sinewave);
   assign crossing = sample_clock_ce & armed_q & ~s[SB-1];

   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      cnt_d     = cnt_q;
      xcnt_d    = xcnt_q;
      win_close = 1'b0;
      timeout   = 1'b0;
      if (sample_clock_ce) begin
         if (crossing)            armed_d = 1'b0;
         else if (s <= NEG_HYST)  armed_d = 1'b1;
         case (state_q)
            S_IDLE: begin
               if (crossing) begin
                  state_d = S_MEASURE;
                  cnt_d   = '0;
                  xcnt_d  = '0;
               end
            end
            S_MEASURE: begin
               // the closing crossing also starts the next window
               if (crossing && (xcnt_q + 1'b1) == XN) begin
                  win_close = 1'b1;
                  cnt_d     = '0;
                  xcnt_d    = '0;
               end else if (cnt_q == CNT_MAX) begin
                  timeout = 1'b1;
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  xcnt_d  = '0;
               end else begin
                  cnt_d  = cnt_q + 1'b1;
                  xcnt_d = xcnt_q + {{NAVG{1'b0}}, crossing};
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- restoring divider ----------------
   // Quotient bits above PB-1 are always zero (D > 2^NAVG), so the partial
   // remainder entering the first of the PB iterations is simply 2^NAVG.
   logic          div_busy_q, div_busy_d;
   logic [IW-1:0] div_it_q, div_it_d;
   logic [DW-1:0] div_den_q, div_den_d;
   logic [DW-1:0] div_rem_q, div_rem_d;
   logic [PB-1:0] div_quo_q, div_quo_d;
   logic          done_q, done_d;
   logic [PB-1:0] q_res_q, q_res_d;
   logic          overrun_q, overrun_d;
   logic [DW:0]   rem_sh;
   logic          ge, last, accept;

   assign rem_sh = {div_rem_q, 1'b0};
   assign ge     = rem_sh >= {1'b0, div_den_q};
   assign last   = div_busy_q && (div_it_q == IW'(PB - 1));
   // the final iteration frees the divider for a load on the same clk
   assign accept = !div_busy_q || last;

   always_comb begin
      div_busy_d = div_busy_q;
      div_it_d   = div_it_q;
      div_den_d  = div_den_q;
      div_rem_d  = div_rem_q;
      div_quo_d  = div_quo_q;
      q_res_d    = q_res_q;
      done_d     = 1'b0;
      if (div_busy_q) begin
         div_rem_d = ge ? DW'(rem_sh - {1'b0, div_den_q}) : DW'(rem_sh);
         div_quo_d = {div_quo_q[PB-2:0], ge};
         div_it_d  = div_it_q + 1'b1;
         if (last) begin
            div_busy_d = 1'b0;
            done_d     = 1'b1;
            q_res_d    = {div_quo_q[PB-2:0], ge};
         end
      end
      if (win_close && accept) begin
         div_busy_d = 1'b1;
         div_it_d   = '0;
         div_den_d  = DW'(cnt_q) + DW'(1);
         div_rem_d  = DW'(1) << NAVG;
         div_quo_d  = '0;
      end
      overrun_d = win_close && !accept;
   end

   // ---------------- output stage ----------------
   logic [PB-1:0] est_q, est_d;
   logic          est_valid_q, est_valid_d;
   logic          signal_lost_q, signal_lost_d;

`ifdef FREQ_EST_IIR_EN
   logic          v1_q, v1_d, first_q, first_d;
   logic [PB-1:0] q1_q, q1_d;
   logic signed [PB:0] diff;

   always_comb begin
      v1_d        = done_q;
      q1_d        = done_q ? q_res_q : q1_q;
      diff        = $signed({1'b0, q1_q}) - $signed({1'b0, est_q});
      est_d       = est_q;
      first_d     = first_q;
      est_valid_d = v1_q;
      if (v1_q) begin
         est_d   = first_q ? q1_q : est_q + PB'(diff >>> 2);
         first_d = 1'b0;
      end
      if (timeout) first_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         q1_q    <= '0;
         first_q <= 1'b1;
      end else begin
         v1_q    <= v1_d;
         q1_q    <= q1_d;
         first_q <= first_d;
      end
   end
`else
   always_comb begin
      est_valid_d = done_q;
      est_d       = done_q ? q_res_q : est_q;
   end
`endif

   // timeout wins over a simultaneous estimate
   always_comb begin
      signal_lost_d = signal_lost_q;
      if (est_valid_d) signal_lost_d = 1'b0;
      if (timeout)     signal_lost_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         armed_q       <= 1'b0;
         cnt_q         <= '0;
         xcnt_q        <= '0;
         div_busy_q    <= 1'b0;
         div_it_q      <= '0;
         div_den_q     <= '0;
         div_rem_q     <= '0;
         div_quo_q     <= '0;
         done_q        <= 1'b0;
         q_res_q       <= '0;
         overrun_q     <= 1'b0;
         est_q         <= '0;
         est_valid_q   <= 1'b0;
         signal_lost_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         armed_q       <= armed_d;
         cnt_q         <= cnt_d;
         xcnt_q        <= xcnt_d;
         div_busy_q    <= div_busy_d;
         div_it_q      <= div_it_d;
         div_den_q     <= div_den_d;
         div_rem_q     <= div_rem_d;
         div_quo_q     <= div_quo_d;
         done_q        <= done_d;
         q_res_q       <= q_res_d;
         overrun_q     <= overrun_d;
         est_q         <= est_d;
         est_valid_q   <= est_valid_d;
         signal_lost_q <= signal_lost_d;
      end
   end

   assign phase_inc_est = est_q;
   assign est_valid     = est_valid_q;
   assign overrun       = overrun_q;
   assign signal_lost   = signal_lost_q;

endmodule

// File: tb/tb_sine_freq_estimator.sv
// tb_sine_freq_estimator
//   Directed bench for sine_freq_estimator. CW is reduced to 12 so the
//   sample-counter timeout is reachable in a short run; all other parameters
//   are the defaults. A model tracks crossings, windows, divider occupancy and
//   result delivery by edge number and is compared with the DUT every cycle.

module tb_sine_freq_estimator;
   localparam int SB = 12, PB = 64, CW = 12, NAVG = 4, HYST = 16;
`ifdef FREQ_EST_IIR_EN
   localparam int LAT = PB + 2;
`else
   localparam int LAT = PB + 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ce  = 1'b0;
   logic [SB-1:0] sinewave = '0;
   logic [PB-1:0] est;
   logic          est_valid, overrun, lost;

   sine_freq_estimator #(.SB(SB), .PB(PB), .CW(CW), .NAVG(NAVG), .HYST(HYST)) dut (
      .clk(clk), .rst(rst), .sample_clock_ce(ce), .sinewave(sinewave),
      .phase_inc_est(est), .est_valid(est_valid), .overrun(overrun), .signal_lost(lost)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct { longint unsigned at; logic [63:0] q; } res_t;
   res_t            pend[$];
   longint unsigned edge_n = 0, ce_n = 0, m_start = 0, m_div_avail = 0;
   int              m_nx = 0;
   bit              m_armed = 0, m_meas = 0;
   logic [63:0]     e_est = '0;
   bit              e_valid = 0, e_ovr = 0, e_lost = 1;
`ifdef FREQ_EST_IIR_EN
   bit              m_first = 1;
   logic signed [64:0] m_d;
`endif

   function automatic logic [63:0] quot(input longint unsigned d);
      logic [127:0] num;
      num = 128'd1 << (PB + NAVG);
      return 64'(num / 128'(d));
   endfunction

   task automatic model_step();
      int  sv;
      bit  xing;
      if (rst) begin
         pend.delete();
         m_armed = 0; m_meas = 0; m_nx = 0; m_div_avail = 0;
         e_est = '0; e_valid = 0; e_ovr = 0; e_lost = 1;
`ifdef FREQ_EST_IIR_EN
         m_first = 1;
`endif
         edge_n++;
         return;
      end
      edge_n++;
      e_valid = 0; e_ovr = 0;
      if (pend.size() != 0 && pend[0].at == edge_n) begin
`ifdef FREQ_EST_IIR_EN
         if (m_first) e_est = pend[0].q;
         else begin
            m_d   = $signed({1'b0, pend[0].q}) - $signed({1'b0, e_est});
            e_est = e_est + 64'(m_d >>> 2);
         end
         m_first = 0;
`else
         e_est = pend[0].q;
`endif
         e_valid = 1; e_lost = 0;
         void'(pend.pop_front());
      end
      if (ce) begin
         sv   = $signed(sinewave);
         xing = m_armed && sv >= 0;
         if (xing) m_armed = 0; else if (sv <= -HYST) m_armed = 1;
         ce_n++;
         if (!m_meas) begin
            if (xing) begin m_meas = 1; m_start = ce_n; m_nx = 0; end
         end else begin
            if (xing) m_nx++;
            if (m_nx == (1 << NAVG)) begin
               if (edge_n >= m_div_avail) begin
                  pend.push_back('{edge_n + LAT, quot(ce_n - m_start)});
                  m_div_avail = edge_n + PB;
               end else e_ovr = 1;
               m_start = ce_n; m_nx = 0;
            end else if (ce_n - m_start == (64'd1 << CW)) begin
               m_meas = 0; e_lost = 1;
`ifdef FREQ_EST_IIR_EN
               m_first = 1;
`endif
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // ---------------- per-cycle compare + event counters ----------------
   int          n_valid = 0, n_ovr = 0;
   logic [63:0] last_est = '0;

   initial forever begin
      @(negedge clk);
      chk("est_valid", 64'(est_valid), 64'(e_valid));
      chk("overrun", 64'(overrun), 64'(e_ovr));
      chk("signal_lost", 64'(lost), 64'(e_lost));
      chk("phase_inc_est", est, e_est);
      if (est_valid) begin n_valid++; last_est = est; end
      if (overrun) n_ovr++;
   end

   // ---------------- stimulus ----------------
   int mode = 0, per = 64, amp = 2000, ph = 0, cyc = 0;

   task automatic set_wave(input int m, input int p, input int a);
      mode = m; per = p; amp = a; ph = 0;
   endtask

   task automatic run(input int ncyc, input int cediv);
      int v;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         if (cyc % cediv == 0) begin
            if (mode == 0) v = 0;
            else if (mode == 1) v = $rtoi(real'(amp) * $sin(6.283185307179586 * real'(ph) / real'(per)));
            else v = (ph % 2 == 0) ? 1000 : -1000;
            ph = (ph + 1) % ((mode == 2) ? 2 : per);
            ce = 1'b1; sinewave = SB'(v);
         end else begin
            ce = 1'b0; sinewave = SB'($urandom);   // must be ignored
         end
         cyc++;
      end
   endtask

   initial begin
      int nv0, guard, lat;
      bit seen;
      // reset
      run(3, 1);
      chk("rst_est", est, 64'h0);
      chk("rst_valid", 64'(est_valid), 64'h0);
      chk("rst_lost", 64'(lost), 64'h1);
      @(posedge clk); #1 rst = 1'b0;

      // 1: P=64 -> 2^58
      set_wave(1, 64, 2000); run(3000, 1);
      chk("t1_est", last_est, 64'h0400000000000000);
      chk("t1_lost", 64'(lost), 64'h0);
      chk("t1_got_valid", 64'(n_valid >= 2), 64'h1);

      // 2: P=100 -> 2^64/100
      set_wave(1, 100, 2000); run(5000, 1);
      chk("t2_est", last_est, 64'h028F5C28F5C28F5C);

      // 3: P=64 with ce every 4th clk
      set_wave(1, 64, 2000); run(12000, 4);
      chk("t3_est", last_est, 64'h0400000000000000);

      // 4: flat input times out, sub-hysteresis sine never arms, then recovery
      set_wave(0, 64, 0); run(4400, 1);
      chk("t4_timeout_lost", 64'(lost), 64'h1);
      nv0 = n_valid;
      set_wave(1, 64, 10); run(4400, 1);
      chk("t4_no_valid", 64'(n_valid - nv0), 64'h0);
      chk("t4_still_lost", 64'(lost), 64'h1);
      set_wave(1, 64, 2000); run(3000, 1);
      chk("t4_recover_est", last_est, 64'h0400000000000000);
      chk("t4_recover_lost", 64'(lost), 64'h0);

      // 5: P=2 -> windows faster than the divider
      nv0 = n_ovr;
      set_wave(2, 2, 1000); run(2000, 1);
      chk("t5_overrun_seen", 64'(n_ovr > nv0), 64'h1);
      chk("t5_est", last_est, 64'h8000000000000000);

      // 6: reset in the middle of a divide
      set_wave(1, 64, 2000);
      guard = 0;
      while (pend.size() == 0 && guard < 3000) begin run(1, 1); guard++; end
      chk("t6_window_closed", 64'(pend.size() != 0), 64'h1);
      run(10, 1);
      @(posedge clk); #1 rst = 1'b1; #1;
      chk("t6_rst_est", est, 64'h0);
      chk("t6_rst_valid", 64'(est_valid), 64'h0);
      chk("t6_rst_lost", 64'(lost), 64'h1);
      run(2, 1);
      @(posedge clk); #1 rst = 1'b0;
      lat = 0; seen = 0;
      while (!seen && lat < 3000) begin
         run(1, 1);
         @(negedge clk);
         if (est_valid) seen = 1;
         lat++;
      end
      chk("t6_full_window_latency", 64'(seen && lat >= 16 * 64 + PB + 1), 64'h1);
      chk("t6_est", est, 64'h0400000000000000);

      run(5, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
